// File: rtl/atri_i2c_sched.sv
// atri_i2c_sched: round-robin sequencer that lets NREQ fabric requesters share one I2C
// PicoBlaze engine through its mailbox RAM.
//
// Per granted transaction it writes the address byte, the clamped length and any write
// bytes into the mailbox, patches the jump slot with JUMP_RUN, then waits for the engine.
// While waiting it collects read bytes and the NAK flag, and it gives up after TIMEOUT
// cycles. It then parks the engine with JUMP_IDLE and pulses done for the granted requester.
//
// Optional feature: define I2C_SCHED_VERIFY_EN to read the mailbox back before the kick.
// A read-back mismatch reports err=11 and parks the engine without starting it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req/req_dev/req_len/req_wdata   per-requester request level and command fields
//   done, rdata, err    one-hot completion pulse, read bytes, status
//   busy                high whenever the sequencer is not idle
//   ram_wr_stb, ram_address, ram_data_in, ram_data_out   mailbox port
//   jump_wr_stb         jump-slot write strobe (data on ram_data_in)
//   pb_done, pb_nak, pb_rd_stb, pb_rd_data                engine status inputs
module atri_i2c_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TIMEOUT   = 50000,
  parameter logic [7:0]  JUMP_RUN  = 8'h40,
  parameter logic [7:0]  JUMP_IDLE = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_dev,
  input  logic [4*NREQ-1:0]    req_len,
  input  logic [64*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      done,
  output logic [63:0]          rdata,
  output logic [1:0]           err,
  output logic                 busy,
  output logic                 ram_wr_stb,
  output logic [7:0]           ram_address,
  output logic [7:0]           ram_data_in,
  input  logic [7:0]           ram_data_out,
  output logic                 jump_wr_stb,
  input  logic                 pb_done,
  input  logic                 pb_nak,
  input  logic                 pb_rd_stb,
  input  logic [7:0]           pb_rd_data
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StArb, StHdr0, StHdr1, StWdat, StVerify, StKick, StWait, StPark, StDone
  } state_e;

`ifdef I2C_SCHED_VERIFY_EN
  localparam state_e StPostWr = StVerify;
`else
  localparam state_e StPostWr = StKick;
`endif

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, grant_q, grant_d, pick, cand;
  logic            found;
  logic [7:0]      dev_q, dev_d;
  logic [3:0]      len_q, len_d, len_raw, wlen;
  logic [63:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]      idx_q, idx_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [1:0]      err_q, err_d;

  // Number of mailbox data bytes actually written: reads carry no payload.
  assign wlen = dev_q[0] ? 4'd0 : len_q;

  // Round-robin search starting at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef I2C_SCHED_VERIFY_EN
  // Byte expected at offset idx_q-1; the RAM returns data one cycle after its address.
  logic [7:0] vexp;
  logic [2:0] wk;
  always_comb begin
    wk = idx_q[2:0] - 3'd3;
    if (idx_q == 4'd1)      vexp = dev_q;
    else if (idx_q == 4'd2) vexp = {4'b0000, len_q};
    else                    vexp = wdata_q[{wk, 3'b000} +: 8];
  end
`else
  logic unused_ram_data_out;
  assign unused_ram_data_out = ^ram_data_out;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    dev_d   = dev_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    len_raw = req_len[{pick, 2'b00} +: 4];
    unique case (state_q)
      StIdle: if (|req) state_d = StArb;
      StArb: begin
        if (found) begin
          grant_d = pick;
          dev_d   = req_dev[{pick, 3'b000} +: 8];
          len_d   = (len_raw > 4'd8) ? 4'd8 : len_raw;
          wdata_d = req_wdata[{pick, 6'b000000} +: 64];
          rdata_d = '0;
          err_d   = 2'b00;
          state_d = StHdr0;
        end else begin
          state_d = StIdle;
        end
      end
      StHdr0: state_d = StHdr1;
      StHdr1: begin
        idx_d   = '0;
        state_d = (wlen == 4'd0) ? StPostWr : StWdat;
      end
      StWdat: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == wlen - 4'd1) begin
          idx_d   = '0;
          state_d = StPostWr;
        end
      end
      StVerify: begin
`ifdef I2C_SCHED_VERIFY_EN
        idx_d = idx_q + 4'd1;
        if (idx_q != 4'd0 && ram_data_out != vexp) begin
          err_d   = 2'b11;
          state_d = StPark;
        end else if (idx_q == wlen + 4'd2) begin
          state_d = StKick;
        end
`else
        state_d = StKick;
`endif
      end
      StKick: begin
        tmo_d   = '0;
        idx_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + 16'd1;
        if (pb_rd_stb && idx_q < len_q) begin
          rdata_d[{idx_q[2:0], 3'b000} +: 8] = pb_rd_data;
          idx_d = idx_q + 4'd1;
        end
        // Completion takes priority over a simultaneous timeout.
        if (pb_done) begin
          err_d   = {1'b0, pb_nak};
          state_d = StPark;
        end else if (tmo_q == TmoLast) begin
          err_d   = 2'b10;
          state_d = StPark;
        end
      end
      StPark: state_d = StDone;
      StDone: begin
        ptr_d   = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + IW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      dev_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dev_q   <= dev_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ram_wr_stb  = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    jump_wr_stb = 1'b0;
    done        = '0;
    unique case (state_q)
      StHdr0: begin
        ram_wr_stb  = 1'b1;
        ram_data_in = dev_q;
      end
      StHdr1: begin
        ram_wr_stb  = 1'b1;
        ram_address = 8'h01;
        ram_data_in = {4'b0000, len_q};
      end
      StWdat: begin
        ram_wr_stb  = 1'b1;
        ram_address = {4'b0000, idx_q} + 8'h02;
        ram_data_in = wdata_q[{idx_q[2:0], 3'b000} +: 8];
      end
      StVerify: ram_address = {4'b0000, idx_q};
      StKick: begin
        jump_wr_stb = 1'b1;
        ram_data_in = JUMP_RUN;
      end
      StPark: begin
        jump_wr_stb = 1'b1;
        ram_data_in = JUMP_IDLE;
      end
      StDone: done[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_atri_i2c_sched.sv
`timescale 1ns/1ps
module tb_atri_i2c_sched;
  localparam int NR   = 4;
  localparam int TMO  = 100;
  localparam int MAXC = 16384;
`ifdef I2C_SCHED_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_dev;
  logic [4*NR-1:0] req_len;
  logic [64*NR-1:0] req_wdata;
  logic [NR-1:0] done;
  logic [63:0] rdata;
  logic [1:0] err;
  logic busy, ram_wr_stb, jump_wr_stb;
  logic [7:0] ram_address, ram_data_in;
  logic [7:0] ram_data_out = 8'h00;
  logic pb_done, pb_nak, pb_rd_stb;
  logic [7:0] pb_rd_data;

  always #5 clk = ~clk;

  atri_i2c_sched #(.NREQ(NR), .TIMEOUT(TMO), .JUMP_RUN(8'h40), .JUMP_IDLE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dev(req_dev), .req_len(req_len),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .ram_wr_stb(ram_wr_stb), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .jump_wr_stb(jump_wr_stb), .pb_done(pb_done),
    .pb_nak(pb_nak), .pb_rd_stb(pb_rd_stb), .pb_rd_data(pb_rd_data)
  );

  // Mailbox RAM with 1-cycle read latency; corrupt_now inverts reads of offset 0x01.
  logic [7:0] mem [256];
  bit corrupt_now = 1'b0;
  always @(posedge clk) begin
    if (ram_wr_stb) mem[ram_address] <= ram_data_in;
    ram_data_out <= (corrupt_now && ram_address == 8'h01) ? ~mem[ram_address]
                                                          : mem[ram_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, want);
    end
  endtask

  // Per-cycle expectations produced by the transaction model.
  typedef struct {
    bit v; bit busy; bit wr; logic [7:0] addr; logic [7:0] wd;
    bit jmp; logic [7:0] jd; logic [3:0] dn; logic [1:0] er;
    logic [63:0] rd; logic [63:0] rmask;
  } exp_t;
  exp_t ex [MAXC];

  always @(negedge clk) begin
    #1;
    if (cyc < MAXC && ex[cyc].v) begin
      chk("busy", 64'(busy), 64'(ex[cyc].busy));
      chk("ram_wr_stb", 64'(ram_wr_stb), 64'(ex[cyc].wr));
      chk("jump_wr_stb", 64'(jump_wr_stb), 64'(ex[cyc].jmp));
      chk("done", 64'(done), 64'(ex[cyc].dn));
      if (ex[cyc].wr) chk("ram_wr", {ram_address, ram_data_in}, {ex[cyc].addr, ex[cyc].wd});
      if (ex[cyc].jmp) chk("jump_data", 64'(ram_data_in), 64'(ex[cyc].jd));
      if (ex[cyc].dn != 0) begin
        chk("err", 64'(err), 64'(ex[cyc].er));
        chk("rdata", rdata & ex[cyc].rmask, ex[cyc].rd);
      end
    end
  end

  logic [7:0]  dev_a [NR];
  logic [3:0]  len_a [NR];
  logic [63:0] wd_a  [NR];
  logic [7:0]  rb [10];
  int ptr = 0;
  int dn_cyc, dn_idx, kicks;
  logic [1:0] dn_err;
  logic [63:0] dn_rd;
  logic [16:0] obs_wr [256];
  logic [8:0]  obs_j  [256];

  function automatic int rr_pick(input int p, input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++) if (m[(p + i) % NR]) return (p + i) % NR;
    return 0;
  endfunction

  // One transaction starting at a negedge where the DUT is idle.
  // L: WAIT cycle carrying pb_done (0 = never). nstb strobes start at WAIT cycle s0+1.
  task automatic run_tx(input logic [NR-1:0] mask, input int L, input bit nak, input int nstb,
                        input int s0, input bit drop, input int rst_at, input bit corrupt);
    int t, g, n, ln, K, W, P, D, V0, e;
    logic [7:0] dv;
    logic [63:0] rexp, rmask;
    t = cyc;
    for (int i = 0; i < NR; i++) begin
      req_dev[8*i +: 8] = dev_a[i];
      req_len[4*i +: 4] = len_a[i];
      req_wdata[64*i +: 64] = wd_a[i];
    end
    req = mask;
    corrupt_now = corrupt;
    g  = rr_pick(ptr, mask);
    dv = dev_a[g];
    ln = (len_a[g] > 4'd8) ? 8 : int'(len_a[g]);
    n  = dv[0] ? 0 : ln;
    V0 = t + 4 + n;
    K  = VEN ? V0 + n + 3 : V0;
    W  = (L >= 1 && L <= TMO) ? K + L : K + TMO;
    P  = (VEN && corrupt) ? V0 + 3 : W + 1;
    D  = P + 1;
    e  = (VEN && corrupt) ? 3 : (L >= 1 && L <= TMO) ? int'(nak) : 2;
    rexp = '0; rmask = '0;
    for (int i = 0; i < nstb && i < ln; i++) begin
      rexp[8*i +: 8] = rb[i];
      rmask[8*i +: 8] = 8'hFF;
    end
    for (int c = t; c <= D && c < MAXC; c++) begin
      ex[c].v = 1; ex[c].busy = (c != t); ex[c].wr = 0; ex[c].addr = 0; ex[c].wd = 0;
      ex[c].jmp = 0; ex[c].jd = 0; ex[c].dn = 0; ex[c].er = 0; ex[c].rd = 0; ex[c].rmask = 0;
    end
    ex[t+2].wr = 1; ex[t+2].addr = 8'h00; ex[t+2].wd = dv;
    ex[t+3].wr = 1; ex[t+3].addr = 8'h01; ex[t+3].wd = 8'(ln);
    for (int k = 0; k < n; k++) begin
      ex[t+4+k].wr = 1; ex[t+4+k].addr = 8'(2 + k); ex[t+4+k].wd = wd_a[g][8*k +: 8];
    end
    if (!(VEN && corrupt)) begin ex[K].jmp = 1; ex[K].jd = 8'h40; end
    ex[P].jmp = 1; ex[P].jd = 8'h00;
    ex[D].dn = 4'(1 << g); ex[D].er = 2'(e); ex[D].rd = rexp; ex[D].rmask = rmask;
    dn_cyc = -1; dn_idx = -1; kicks = 0;
    for (int c = t; c <= D; c++) begin
      pb_done = 0; pb_nak = 0; pb_rd_stb = 0; pb_rd_data = 0;
      if (c >= K + 1 + s0 && c < K + 1 + s0 + nstb) begin
        pb_rd_stb = 1; pb_rd_data = rb[c - (K + 1 + s0)];
      end
      if (L >= 1 && c == K + L) begin pb_done = 1; pb_nak = nak; end
      if (drop && c == t + 5) req = '0;
      if (rst_at > 0 && c == K + rst_at) begin
        for (int k = c; k <= D && k < MAXC; k++) ex[k].v = 0;
        rst_n = 0; pb_done = 0; pb_rd_stb = 0; pb_rd_data = 0;
        #1;
        chk("rst_mid_rdata", rdata, 64'h0);
        chk("rst_mid_ctl", {done, err, busy, ram_wr_stb, jump_wr_stb, ram_address, ram_data_in},
            64'h0);
        @(negedge clk);
        chk("rst_mid_idle", 64'(busy), 64'h0);
        rst_n = 1; req = '0; ptr = 0; corrupt_now = 0;
        return;
      end
      if (c - t < 256) begin
        obs_wr[c-t] = {ram_wr_stb, ram_address, ram_data_in};
        obs_j[c-t]  = {jump_wr_stb, ram_data_in};
      end
      if (jump_wr_stb && ram_data_in == 8'h40) kicks++;
      if (done != 0) begin
        dn_cyc = c - t; dn_err = err; dn_rd = rdata;
        for (int i = 0; i < NR; i++) if (done[i]) dn_idx = i;
      end
      @(negedge clk);
    end
    corrupt_now = 0;
    ptr = (g + 1) % NR;
  endtask

  int got [4];
  int m, g, ln, nst, s0, L;
  initial begin
    req = '0; req_dev = '0; req_len = '0; req_wdata = '0;
    pb_done = 0; pb_nak = 0; pb_rd_stb = 0; pb_rd_data = 0;
    for (int i = 0; i < NR; i++) begin
      dev_a[i] = 8'hA0; len_a[i] = 4'd0; wd_a[i] = 64'h0;
    end
    for (int i = 0; i < 10; i++) rb[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_ctl", {done, err, busy, ram_wr_stb, jump_wr_stb, ram_address, ram_data_in}, 64'h0);
    rst_n = 1;

    // Arbitration with req=1011 held: grants 0,1,3,0.
    for (int i = 0; i < NR; i++) begin
      dev_a[i] = 8'(8'hA0 + 8'(2 * i)); len_a[i] = 4'd1; wd_a[i] = {$urandom, $urandom};
    end
    for (int k = 0; k < 4; k++) begin
      run_tx(4'b1011, 3, 0, 0, 0, 0, 0, 0);
      got[k] = dn_idx;
    end
    chk("arb_grant0", 64'(got[0]), 64'd0);
    chk("arb_grant1", 64'(got[1]), 64'd1);
    chk("arb_grant2", 64'(got[2]), 64'd3);
    chk("arb_grant3", 64'(got[3]), 64'd0);

    // Directed write: A0, len 2, bytes 11,22; pb_done on WAIT cycle 5 (ptr is at 1 now).
    dev_a[1] = 8'hA0; len_a[1] = 4'd2; wd_a[1] = 64'h2211;
    run_tx(4'b0010, 5, 0, 0, 0, 0, 0, 0);
    chk("wr_byte3", 64'(obs_wr[5]), {47'h0, 1'b1, 8'h03, 8'h22});
    if (!VEN) begin
      chk("wr_kick", 64'(obs_j[6]), {55'h0, 1'b1, 8'h40});
      chk("wr_done_cycle", 64'(dn_cyc), 64'd13);
    end
    chk("wr_err", 64'(dn_err), 64'd0);

    // Directed read: A1, len 3, four strobes; 8D dropped.
    dev_a[2] = 8'hA1; len_a[2] = 4'd3;
    rb[0] = 8'h5A; rb[1] = 8'h6B; rb[2] = 8'h7C; rb[3] = 8'h8D;
    run_tx(4'b0100, 6, 0, 4, 0, 0, 0, 0);
    chk("rd_rdata", dn_rd, 64'h7C6B5A);
    chk("rd_err", 64'(dn_err), 64'd0);

    // Timeout: read with len 0, no pb_done.
    dev_a[3] = 8'hA1; len_a[3] = 4'd0;
    run_tx(4'b1000, 0, 0, 0, 0, 0, 0, 0);
    chk("tmo_err", 64'(dn_err), 64'd2);
    if (!VEN) begin
      chk("tmo_done_cycle", 64'(dn_cyc), 64'd106);
      chk("tmo_park", 64'(obs_j[105]), {55'h0, 1'b1, 8'h00});
    end

    // NAK, and pb_done colliding with the expiry cycle.
    dev_a[0] = 8'hA0; len_a[0] = 4'd1;
    run_tx(4'b0001, 3, 1, 0, 0, 0, 0, 0);
    chk("nak_err", 64'(dn_err), 64'd1);
    run_tx(4'b0010, TMO, 0, 0, 0, 0, 0, 0);
    chk("coll_err_ok", 64'(dn_err), 64'd0);
    run_tx(4'b0100, TMO, 1, 0, 0, 0, 0, 0);
    chk("coll_err_nak", 64'(dn_err), 64'd1);

`ifdef I2C_SCHED_VERIFY_EN
    dev_a[3] = 8'hA0; len_a[3] = 4'd2; wd_a[3] = 64'h2211;
    run_tx(4'b1000, 5, 0, 0, 0, 0, 0, 1);
    chk("vfy_err", 64'(dn_err), 64'd3);
    chk("vfy_no_kick", 64'(kicks), 64'd0);
`endif

    // Reset pulsed during WAIT after two bytes were collected.
    dev_a[0] = 8'hA1; len_a[0] = 4'd3; rb[0] = 8'h33; rb[1] = 8'h44;
    run_tx(4'b0001, 0, 0, 2, 0, 0, 10, 0);

    // Randomized transactions.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NR; i++) begin
        dev_a[i] = 8'($urandom); len_a[i] = 4'($urandom_range(0, 15));
        wd_a[i] = {$urandom, $urandom};
      end
      for (int i = 0; i < 10; i++) rb[i] = 8'($urandom);
      m   = int'($urandom_range(1, 15));
      g   = rr_pick(ptr, 4'(m));
      ln  = (len_a[g] > 4'd8) ? 8 : int'(len_a[g]);
      nst = dev_a[g][0] ? int'($urandom_range(0, 32'(ln + 2))) : 0;
      s0  = int'($urandom_range(0, 3));
      L   = s0 + nst + 1 + int'($urandom_range(0, 4));
      run_tx(4'(m), L, 1'($urandom_range(0, 1)), nst, s0, ($urandom_range(0, 4) == 0), 0, 0);
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
